// File: rtl/spi_master_gen_if.sv
// Command-side bundle of the SPI frame engine: request, frame settings,
// and the busy/ack/RX-data handshake back to the requesting FSM.
interface spi_master_gen_if #(
    parameter int DATA_W = 32,
    parameter int DIV_W  = 16
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    logic              i_wr_req;
    logic [DATA_W-1:0] i_data_in;
    logic [LEN_W-1:0]  i_frame_len;
    logic [DIV_W-1:0]  i_clk_div;
    logic              i_cpol;
    logic              i_cpha;
    logic              i_lsb_first;
    logic              i_cs_keep;
    logic              o_busy;
    logic              o_wr_ack;
    logic [DATA_W-1:0] o_data_out;

    // Requester side: issues frames and watches for completion.
    modport master (
        output i_wr_req, i_data_in, i_frame_len, i_clk_div,
               i_cpol, i_cpha, i_lsb_first, i_cs_keep,
        input  o_busy, o_wr_ack, o_data_out
    );

    // Engine side: consumes frame settings and reports completion.
    modport slave (
        input  i_wr_req, i_data_in, i_frame_len, i_clk_div,
               i_cpol, i_cpha, i_lsb_first, i_cs_keep,
        output o_busy, o_wr_ack, o_data_out
    );
endinterface

// File: rtl/spi_master_gen.sv
// SPI master frame engine: variable frame length, runtime CPOL/CPHA,
// selectable bit order, automatic chip select with setup/hold and
// optional CS-keep across consecutive frames. All pin outputs registered.
module spi_master_gen #(
    parameter int DATA_W       = 32,
    parameter int DIV_W        = 16,
    parameter int CS_SETUP_CYC = 1,
    parameter int CS_HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    spi_master_gen_if.slave  bus,
    output logic             o_spi_cs,
    output logic             o_spi_dclk,
    output logic             o_spi_mosi,
    input  logic             i_spi_miso
);
    localparam int LEN_W = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_LEAD,
        ST_TRAIL,
        ST_CS_HOLD,
        ST_DONE
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [DIV_W-1:0]  r_cnt;
    logic [DIV_W-1:0]  w_nextCnt;
    logic [LEN_W-1:0]  r_pulse;
    logic [DATA_W-1:0] r_data;
    logic [LEN_W-1:0]  r_len;
    logic [DIV_W-1:0]  r_div;
    logic              r_cpol;
    logic              r_cpha;
    logic              r_lsb;
    logic              r_keep;
    logic              r_kept;
    logic [DATA_W-1:0] r_rx;
    logic              r_miso;
    logic              r_busy;
    logic              r_ack;
    logic [DATA_W-1:0] r_dout;
    logic              r_cs;
    logic              r_dclk;
    logic              r_mosi;

    logic [LEN_W-1:0]  w_lenEff;
    logic [DIV_W-1:0]  w_divEff;
    logic              w_phaseEnd;
    logic              w_firstBit;
    logic              w_txBit;
    logic [LEN_W-1:0]  w_rxIdx;
    logic [LEN_W-1:0]  w_rxPos;
    logic [DATA_W-1:0] w_rxMask;

    // Returns bit idx of d without a wide-index part-select.
    function automatic logic f_pick(input logic [DATA_W-1:0] d,
                                    input logic [LEN_W-1:0]  idx);
        logic [DATA_W-1:0] s;
        s = d >> idx;
        return s[0];
    endfunction

    // Zero or oversize lengths mean a full-width frame; a zero divider means 1.
    assign w_lenEff = ((bus.i_frame_len == '0) || (bus.i_frame_len > LEN_W'(DATA_W)))
                      ? LEN_W'(DATA_W) : bus.i_frame_len;
    assign w_divEff = (bus.i_clk_div == '0) ? DIV_W'(1) : bus.i_clk_div;

    assign w_phaseEnd = (r_cnt == '0);

    // Bit 0 of the frame is already on MOSI at accept time in CPHA=0.
    assign w_firstBit = f_pick(bus.i_data_in,
                               bus.i_lsb_first ? '0 : (w_lenEff - LEN_W'(1)));

    // r_pulse is the index of the next bit to drive in both LEAD and TRAIL.
    assign w_txBit = f_pick(r_data, r_lsb ? r_pulse : (r_len - LEN_W'(1) - r_pulse));

    // Received bit index: in TRAIL the pulse counter has already advanced.
    assign w_rxIdx  = (r_state == ST_TRAIL) ? (r_pulse - LEN_W'(1)) : r_pulse;
    assign w_rxPos  = r_lsb ? w_rxIdx : (r_len - LEN_W'(1) - w_rxIdx);
    assign w_rxMask = DATA_W'(r_miso) << w_rxPos;

    // State and phase-counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
        end
    end

    // Next state and phase counter; each timed phase ends when the counter hits zero.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_wr_req) begin
                    if (r_kept) begin
                        w_nextState = ST_LEAD;
                        w_nextCnt   = w_divEff - DIV_W'(1);
                    end else begin
                        w_nextState = ST_CS_SETUP;
                        w_nextCnt   = DIV_W'(CS_SETUP_CYC - 1);
                    end
                end
            end
            ST_CS_SETUP: begin
                if (w_phaseEnd) begin
                    w_nextState = ST_LEAD;
                    w_nextCnt   = r_div - DIV_W'(1);
                end else begin
                    w_nextCnt = r_cnt - DIV_W'(1);
                end
            end
            ST_LEAD: begin
                if (w_phaseEnd) begin
                    w_nextState = ST_TRAIL;
                    w_nextCnt   = r_div - DIV_W'(1);
                end else begin
                    w_nextCnt = r_cnt - DIV_W'(1);
                end
            end
            ST_TRAIL: begin
                if (w_phaseEnd) begin
                    if (r_pulse != r_len) begin
                        w_nextState = ST_LEAD;
                        w_nextCnt   = r_div - DIV_W'(1);
                    end else if (r_keep) begin
                        w_nextState = ST_DONE;
                    end else begin
                        w_nextState = ST_CS_HOLD;
                        w_nextCnt   = DIV_W'(CS_HOLD_CYC - 1);
                    end
                end else begin
                    w_nextCnt = r_cnt - DIV_W'(1);
                end
            end
            ST_CS_HOLD: begin
                if (w_phaseEnd) begin
                    w_nextState = ST_DONE;
                end else begin
                    w_nextCnt = r_cnt - DIV_W'(1);
                end
            end
            ST_DONE: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // Frame datapath and registered pins, updated at phase boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pulse <= '0;
            r_data  <= '0;
            r_len   <= '0;
            r_div   <= '0;
            r_cpol  <= 1'b0;
            r_cpha  <= 1'b0;
            r_lsb   <= 1'b0;
            r_keep  <= 1'b0;
            r_kept  <= 1'b0;
            r_rx    <= '0;
            r_miso  <= 1'b0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_dout  <= '0;
            r_cs    <= 1'b1;
            r_dclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else begin
            r_miso <= i_spi_miso;
            r_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_dclk <= bus.i_cpol;
                    if (bus.i_wr_req) begin
                        r_data  <= bus.i_data_in;
                        r_len   <= w_lenEff;
                        r_div   <= w_divEff;
                        r_cpol  <= bus.i_cpol;
                        r_cpha  <= bus.i_cpha;
                        r_lsb   <= bus.i_lsb_first;
                        r_keep  <= bus.i_cs_keep;
                        r_pulse <= '0;
                        r_rx    <= '0;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b0;
                        r_mosi  <= bus.i_cpha ? 1'b0 : w_firstBit;
                    end
                end
                ST_LEAD: begin
                    if (w_phaseEnd) begin
                        r_dclk  <= ~r_dclk;
                        r_pulse <= r_pulse + LEN_W'(1);
                        if (r_cpha) begin
                            r_mosi <= w_txBit;
                        end else begin
                            r_rx <= r_rx | w_rxMask;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (w_phaseEnd) begin
                        r_dclk <= ~r_dclk;
                        if (r_cpha) begin
                            r_rx <= r_rx | w_rxMask;
                        end else if (r_pulse != r_len) begin
                            r_mosi <= w_txBit;
                        end
                    end
                end
                ST_DONE: begin
                    r_ack  <= 1'b1;
                    r_busy <= 1'b0;
                    r_mosi <= 1'b0;
                    r_dclk <= r_cpol;
                    r_cs   <= ~r_keep;
                    r_kept <= r_keep;
                    r_dout <= r_rx;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_busy     = r_busy;
    assign bus.o_wr_ack   = r_ack;
    assign bus.o_data_out = r_dout;
    assign o_spi_cs       = r_cs;
    assign o_spi_dclk     = r_dclk;
    assign o_spi_mosi     = r_mosi;
endmodule

// File: tb/tb_spi_master_gen.sv
// Directed self-checking bench for spi_master_gen: modes 0-3, bit order,
// CS-keep chaining, length/divider clamping, held request and mid-frame reset.
module tb_spi_master_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spiCs;
    logic spiDclk;
    logic spiMosi;
    logic spiMiso;
    logic loopback = 1'b1;
    logic patBit = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    int latency;
    int pulses;
    int firstEdge;
    int csGlitch;
    int ackCount;
    logic [31:0] mosiCap;

    spi_master_gen_if #(.DATA_W(32), .DIV_W(16)) bus ();

    spi_master_gen #(
        .DATA_W(32), .DIV_W(16), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_spi_cs   (spiCs),
        .o_spi_dclk (spiDclk),
        .o_spi_mosi (spiMosi),
        .i_spi_miso (spiMiso)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // MISO either loops MOSI back or follows the scripted slave pattern.
    assign spiMiso = loopback ? spiMosi : patBit;

    // Scripted slave: bit i of a patLen-bit word in the frame's bit order.
    function automatic logic patBitOf(input logic [31:0] p, input int n, input int i, input logic lsbF);
        logic [31:0] s;
        if (i >= n) return 1'b0;
        s = lsbF ? (p >> i) : (p >> (n - 1 - i));
        return s[0];
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Runs one frame and measures it at each falling clk edge.
    // patLen==0 selects MISO loopback; otherwise the slave plays pat.
    task automatic applyStimulus(input logic [31:0] data, input logic [5:0] len,
                                 input logic [15:0] div, input logic cpol, input logic cpha,
                                 input logic lsb, input logic keep, input logic hold,
                                 input logic [31:0] pat, input int patLen);
        int cnt;
        int idx;
        logic prevDclk;
        logic done;
        @(negedge clk);
        bus.i_wr_req    = 1'b1;
        bus.i_data_in   = data;
        bus.i_frame_len = len;
        bus.i_clk_div   = div;
        bus.i_cpol      = cpol;
        bus.i_cpha      = cpha;
        bus.i_lsb_first = lsb;
        bus.i_cs_keep   = keep;
        loopback = (patLen == 0);
        idx = 0;
        patBit = patBitOf(pat, patLen, idx, lsb);
        prevDclk = cpol;
        pulses = 0;
        firstEdge = -1;
        mosiCap = '0;
        latency = -1;
        csGlitch = 0;
        cnt = 0;
        done = 1'b0;
        while (!done && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1 && !hold) bus.i_wr_req = 1'b0;
            if (cnt == 2) begin
                bus.i_data_in   = ~data;
                bus.i_frame_len = 6'd4;
                bus.i_clk_div   = 16'd7;
            end
            if (spiDclk !== prevDclk) begin
                if (firstEdge < 0) firstEdge = cnt - 1;
                if (spiDclk !== cpol) begin
                    pulses++;
                    if (!cpha) begin
                        mosiCap = {mosiCap[30:0], spiMosi};
                        idx++;
                        patBit = patBitOf(pat, patLen, idx, lsb);
                    end
                end else if (cpha) begin
                    mosiCap = {mosiCap[30:0], spiMosi};
                    idx++;
                    patBit = patBitOf(pat, patLen, idx, lsb);
                end
                prevDclk = spiDclk;
            end
            if (bus.o_busy && spiCs) csGlitch++;
            if (bus.o_wr_ack) begin
                latency = cnt - 1;
                done = 1'b1;
                bus.i_wr_req = 1'b0;
            end
        end
    endtask

    initial begin
        bus.i_wr_req    = 1'b0;
        bus.i_data_in   = '0;
        bus.i_frame_len = '0;
        bus.i_clk_div   = '0;
        bus.i_cpol      = 1'b0;
        bus.i_cpha      = 1'b0;
        bus.i_lsb_first = 1'b0;
        bus.i_cs_keep   = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        checkOutput("rst_cs", spiCs, 1);
        checkOutput("rst_dclk", spiDclk, 0);
        checkOutput("rst_mosi", spiMosi, 0);
        checkOutput("rst_busy", bus.o_busy, 0);
        checkOutput("rst_ack", bus.o_wr_ack, 0);
        checkOutput("rst_dout", bus.o_data_out, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Mode 0, N=8, DIV=2, MSB-first, loopback
        applyStimulus(32'hA5, 6'd8, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        checkOutput("m0_latency", latency, 35);
        checkOutput("m0_pulses", pulses, 8);
        checkOutput("m0_first_edge", firstEdge, 3);
        checkOutput("m0_mosi", mosiCap, 32'hA5);
        checkOutput("m0_dout", bus.o_data_out, 32'h0000_00A5);
        checkOutput("m0_cs_low_busy", csGlitch, 0);
        checkOutput("m0_cs_released", spiCs, 1);

        // Mode 3, N=12, DIV=1, LSB-first, slave returns 0xF0F
        applyStimulus(32'h3C1, 6'd12, 16'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'hF0F, 12);
        checkOutput("m3_latency", latency, 27);
        checkOutput("m3_pulses", pulses, 12);
        checkOutput("m3_mosi", mosiCap, 32'h83C);
        checkOutput("m3_dout", bus.o_data_out, 32'h0000_0F0F);
        checkOutput("m3_dclk_idle", spiDclk, 1);

        // Mode 1, N=32, DIV=3, loopback
        applyStimulus(32'hDEADBEEF, 6'd32, 16'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        checkOutput("m1_latency", latency, 195);
        checkOutput("m1_pulses", pulses, 32);
        checkOutput("m1_first_edge", firstEdge, 4);
        checkOutput("m1_mosi", mosiCap, 32'hDEADBEEF);
        checkOutput("m1_dout", bus.o_data_out, 32'hDEADBEEF);

        // Mode 2, N=32, DIV=3, loopback
        applyStimulus(32'hDEADBEEF, 6'd32, 16'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        checkOutput("m2_latency", latency, 195);
        checkOutput("m2_pulses", pulses, 32);
        checkOutput("m2_first_edge", firstEdge, 4);
        checkOutput("m2_dout", bus.o_data_out, 32'hDEADBEEF);

        // Two chained frames: cs_keep=1 then cs_keep=0, N=8, DIV=1
        applyStimulus(32'h3C, 6'd8, 16'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h96, 8);
        checkOutput("keep1_latency", latency, 18);
        checkOutput("keep1_dout", bus.o_data_out, 32'h96);
        checkOutput("keep1_cs_at_ack", spiCs, 0);
        repeat (2) @(negedge clk);
        checkOutput("keep1_cs_between", spiCs, 0);
        applyStimulus(32'h69, 6'd8, 16'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h5A, 8);
        checkOutput("keep2_first_edge", firstEdge, 1);
        checkOutput("keep2_latency", latency, 18);
        checkOutput("keep2_mosi", mosiCap, 32'h69);
        checkOutput("keep2_dout", bus.o_data_out, 32'h5A);
        checkOutput("keep2_cs_at_ack", spiCs, 1);
        checkOutput("keep2_cs_low_busy", csGlitch, 0);

        // N=0 and DIV=0 clamp to a 32-bit frame at DIV=1
        applyStimulus(32'hCAFEF00D, 6'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h12345678, 32);
        checkOutput("clamp_latency", latency, 67);
        checkOutput("clamp_pulses", pulses, 32);
        checkOutput("clamp_mosi", mosiCap, 32'hCAFEF00D);
        checkOutput("clamp_dout", bus.o_data_out, 32'h12345678);

        // Request held high through the frame: no re-latch, one ack
        applyStimulus(32'h5A, 6'd8, 16'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 0);
        checkOutput("hold_latency", latency, 35);
        checkOutput("hold_dout", bus.o_data_out, 32'h5A);
        repeat (3) @(negedge clk);
        checkOutput("hold_no_restart", bus.o_busy, 0);

        // Reset in the middle of a frame aborts it with no ack
        bus.i_wr_req    = 1'b1;
        bus.i_data_in   = 32'hFF;
        bus.i_frame_len = 6'd8;
        bus.i_clk_div   = 16'd2;
        bus.i_cpol      = 1'b0;
        bus.i_cpha      = 1'b0;
        bus.i_cs_keep   = 1'b0;
        @(negedge clk);
        bus.i_wr_req = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("abort_busy_before", bus.o_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_cs", spiCs, 1);
        checkOutput("abort_dclk", spiDclk, 0);
        checkOutput("abort_busy", bus.o_busy, 0);
        checkOutput("abort_ack", bus.o_wr_ack, 0);
        rst = 1'b0;
        ackCount = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.o_wr_ack) ackCount++;
        end
        checkOutput("abort_no_ack", ackCount, 0);
        checkOutput("abort_idle_busy", bus.o_busy, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
